// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and helpers for booth_signed_divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [63:0] neg_if(input logic [63:0] v, input logic s);
    return s ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on magnitudes.
module div_step #(
  parameter int nb = 8
) (
  input  logic [nb:0]   r,
  input  logic [nb-1:0] d,
  input  logic          din,
  output logic [nb:0]   r_n,
  output logic          q
);
  logic [nb+1:0] sh, diff;
  always_comb begin
    sh = {r, din};
    diff = sh - {2'b00, d};
    q = ~diff[nb+1];
    r_n = (nb+1)'(q ? diff : sh);
  end
endmodule

// File: rtl/booth_signed_divider.sv
// booth_signed_divider: sequential signed divider, one quotient bit per clock.
// Define DIV_ZERO_DETECT_EN to bypass zero divisors straight to the result stage.
module booth_signed_divider
  import div_pkg::*;
#(
  parameter int nb = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [nb-1:0] A,
  input  logic [nb-1:0] B,
  output logic [nb-1:0] Quotient,
  output logic [nb-1:0] Remainder,
  output logic          ready,
  output logic          ovf,
  output logic          dz
);
`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif
  localparam int CW = clog2(nb + 1);
  state_t state;
  logic [CW-1:0] count;
  logic [nb:0] rem, rem_n;
  logic [nb-1:0] dvd, dvs;
  logic sa, sb, ovf_p, dz_p, q_bit;
  div_step #(.nb(nb)) u_step (
    .r  (rem),
    .d  (dvs),
    .din(dvd[nb-1]),
    .r_n(rem_n),
    .q  (q_bit)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      rem <= '0;
      dvd <= '0;
      dvs <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      ovf_p <= 1'b0;
      dz_p <= 1'b0;
      Quotient <= '0;
      Remainder <= '0;
      ready <= 1'b1;
      ovf <= 1'b0;
      dz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd <= nb'(neg_if(64'(A), A[nb-1]));
          dvs <= nb'(neg_if(64'(B), B[nb-1]));
          sa <= A[nb-1];
          sb <= B[nb-1];
          rem <= '0;
          count <= CW'(nb);
          ovf_p <= (A == {1'b1, {(nb-1){1'b0}}}) && (B == '1);
          dz_p <= DZ && (B == '0);
          state <= (DZ && (B == '0)) ? FIX : CALC;
          ready <= 1'b0;
        end
        CALC: begin
          rem <= rem_n;
          dvd <= {dvd[nb-2:0], q_bit};
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          // dvd now holds the magnitude quotient; on a zero-divisor bypass it still holds |A|
          Quotient <= dz_p ? '0 : nb'(neg_if(64'(dvd), sa ^ sb));
          Remainder <= nb'(neg_if(64'(dz_p ? dvd : rem[nb-1:0]), sa));
          ovf <= ovf_p;
          dz <= dz_p;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
